// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl
// FIFO controller that keeps its storage in an external simple dual-port RAM.
// The RAM has a one-cycle read latency. A 2-entry register buffer on the read
// side hides that latency, so both sides can move one word per cycle.
//
// Ports
//   clk, resetn            single clock; asynchronous active-low reset
//   s_data/s_valid/s_ready write-side valid/ready handshake
//   m_data/m_valid/m_ready read-side valid/ready handshake
//   mem_we/mem_waddr/...   RAM write port (mem_din carries s_data)
//   mem_raddr/mem_dout     RAM read port; raddr is sampled on the clock edge
//   count                  total words held: RAM + read in flight + output buffer

module mem_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  resetn,

    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,

    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,

    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_dout,

    output logic [ADDR_WIDTH+1:0] count
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   ram_count_q, ram_count_d;
    logic                  rd_pending_q, rd_pending_d;
    logic [1:0]            obuf_count_q, obuf_count_d;
    logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;   // head entry
    logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;
    // Held low by reset and set on the first edge afterwards, so s_ready stays
    // low throughout reset even though ram_count is zero then.
    logic                  accept_en_q;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  capture;
    logic [2:0]            obuf_after_pop;

    // ------------------------------------------------------------------
    // Handshakes and read issue
    // ------------------------------------------------------------------
    always_comb begin
        // ram_count tops out at 2**ADDR_WIDTH, so its MSB alone flags "full".
        s_ready = accept_en_q && !ram_count_q[ADDR_WIDTH];
        m_valid = (obuf_count_q != 2'd0);
        m_data  = obuf0_q;

        push    = s_valid && s_ready;
        pop     = m_valid && m_ready;
        capture = rd_pending_q;

        // Buffer occupancy once the in-flight word lands and the current pop
        // leaves; a new read may only be issued if that leaves a free slot.
        // pop implies obuf_count >= 1, so this never underflows.
        obuf_after_pop = {1'b0, obuf_count_q} + {2'b00, rd_pending_q} - {2'b00, pop};
        // ram_count excludes this cycle's push, so the issued address is never
        // the one being written right now.
        issue = (ram_count_q != '0) && (obuf_after_pop < 3'd2);
    end

    // ------------------------------------------------------------------
    // RAM port drive
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = push;
        mem_waddr = wr_ptr_q;
        mem_din   = s_data;
        mem_raddr = rd_ptr_q;
    end

    // ------------------------------------------------------------------
    // Pointer / counter next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_pending_d = issue;

        if (push) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        ram_count_d = ram_count_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(issue);
    end

    // ------------------------------------------------------------------
    // Output buffer next state (2-entry in-order FIFO, entry 0 is head)
    // ------------------------------------------------------------------
    always_comb begin
        obuf0_d      = obuf0_q;
        obuf1_d      = obuf1_q;
        obuf_count_d = obuf_count_q;

        // A capture only happens while at most one entry is occupied, since
        // issue is gated on obuf_count + rd_pending staying below 2.
        case ({capture, pop})
            2'b01: begin
                obuf0_d      = obuf1_q;
                obuf_count_d = obuf_count_q - 2'd1;
            end
            2'b10: begin
                if (obuf_count_q == 2'd0) begin
                    obuf0_d = mem_dout;
                end else begin
                    obuf1_d = mem_dout;
                end
                obuf_count_d = obuf_count_q + 2'd1;
            end
            2'b11: begin
                // Head leaves; the incoming word joins behind whatever remains.
                if (obuf_count_q == 2'd1) begin
                    obuf0_d = mem_dout;
                end else begin
                    obuf0_d = obuf1_q;
                    obuf1_d = mem_dout;
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Occupancy report
    // ------------------------------------------------------------------
    always_comb begin
        count = (ADDR_WIDTH + 2)'(ram_count_q)
              + (ADDR_WIDTH + 2)'(rd_pending_q)
              + (ADDR_WIDTH + 2)'(obuf_count_q);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            ram_count_q  <= '0;
            rd_pending_q <= 1'b0;
            obuf_count_q <= 2'd0;
            obuf0_q      <= '0;
            obuf1_q      <= '0;
            accept_en_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ram_count_q  <= ram_count_d;
            rd_pending_q <= rd_pending_d;
            obuf_count_q <= obuf_count_d;
            obuf0_q      <= obuf0_d;
            obuf1_q      <= obuf1_d;
            accept_en_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb_mem_fifo_ctrl
// Self-checking bench for mem_fifo_ctrl with ADDR_WIDTH=2, DATA_WIDTH=8.
// A behavioural RAM with one-cycle read latency sits on the memory port.
// The reference model is a queue of accepted-but-not-yet-delivered words.
// Its size is the expected count, and its head is the expected m_data on every pop.

module tb_mem_fifo_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 2;

    logic          clk;
    logic          resetn;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_din;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_dout;
    logic [AW+1:0] count;

    mem_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_din   (mem_din),
        .mem_raddr (mem_raddr),
        .mem_dout  (mem_dout),
        .count     (count)
    );

    // External simple dual-port RAM, read latency 1.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_din;
        mem_dout <= ram[mem_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_q [$];

    // Per-cycle samples, taken on the falling edge inside tick.
    logic          smp_mvalid, smp_sready, smp_push, smp_pop;
    logic [DW-1:0] smp_mdata, smp_exp;
    int            smp_count, exp_count;

    // One clock cycle: drive inputs, sample mid-cycle, update the model,
    // then return just after the next rising edge.
    task automatic tick(input logic sv, input logic [DW-1:0] sd, input logic mr);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        @(negedge clk);
        smp_mvalid = m_valid;
        smp_mdata  = m_data;
        smp_sready = s_ready;
        smp_count  = int'(count);
        exp_count  = model_q.size();
        smp_pop    = m_valid && m_ready;
        smp_push   = s_valid && s_ready;
        smp_exp    = (model_q.size() != 0) ? model_q[0] : 8'hxx;
        if (smp_pop && model_q.size() != 0) void'(model_q.pop_front());
        if (smp_push) model_q.push_back(s_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h55;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
        n_checks++;
        if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        n_checks++;
        if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%b exp=0", mem_we); end
        n_checks++;
        if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
        n_checks++;
        if (mem_raddr !== 2'd0) begin n_fail++; $display("FAIL reset_raddr got=%0d exp=0", mem_raddr); end
        s_valid = 1'b0;
        resetn  = 1'b1;
        model_q.delete();
        @(posedge clk);
        #1;
        n_checks++;
        if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready got=%b exp=1", s_ready); end
    endtask

    task automatic test_single();
        int first_pop = -1;
        for (int k = 0; k < 8; k++) begin
            tick((k == 0), 8'hA5, 1'b1);
            n_checks++;
            if (smp_count !== exp_count) begin
                n_fail++; $display("FAIL single_count t=%0d got=%0d exp=%0d", k, smp_count, exp_count);
            end
            if (smp_pop) begin
                if (first_pop < 0) first_pop = k;
                n_checks++;
                if (smp_mdata !== smp_exp) begin
                    n_fail++; $display("FAIL single_data got=%h exp=%h", smp_mdata, smp_exp);
                end
            end
        end
        n_checks++;
        if (first_pop !== 3) begin n_fail++; $display("FAIL single_latency got=%0d exp=3", first_pop); end
    endtask

    task automatic test_fill();
        int       accepted = 0;
        int       pops     = 0;
        logic [7:0] d;
        for (int k = 0; k < 10; k++) begin
            d = 8'(accepted + 1);
            tick(accepted < 7, d, 1'b0);
            if (smp_push) accepted++;
            n_checks++;
            if (smp_count !== exp_count) begin
                n_fail++; $display("FAIL fill_count t=%0d got=%0d exp=%0d", k, smp_count, exp_count);
            end
        end
        n_checks++;
        if (accepted !== 6) begin n_fail++; $display("FAIL fill_accepted got=%0d exp=6", accepted); end
        n_checks++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_s_ready got=%b exp=0", s_ready); end
        n_checks++;
        if (count !== 4'd6) begin n_fail++; $display("FAIL fill_count_full got=%0d exp=6", count); end
        for (int k = 0; k < 14; k++) begin
            tick(1'b0, 8'h00, 1'b1);
            if (smp_pop) begin
                pops++;
                n_checks++;
                if (smp_mdata !== smp_exp) begin
                    n_fail++; $display("FAIL fill_data got=%h exp=%h", smp_mdata, smp_exp);
                end
            end
        end
        n_checks++;
        if (pops !== 6) begin n_fail++; $display("FAIL fill_pops got=%0d exp=6", pops); end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        int first_pop = -1;
        int last_pop = -1;
        int pops = 0;
        for (int k = 0; k < 30; k++) begin
            tick(idx < 20, 8'(idx), 1'b1);
            if (smp_push) idx++;
            n_checks++;
            if (smp_count !== exp_count) begin
                n_fail++; $display("FAIL stream_count t=%0d got=%0d exp=%0d", k, smp_count, exp_count);
            end
            if (smp_pop) begin
                if (first_pop < 0) first_pop = k;
                last_pop = k;
                pops++;
                n_checks++;
                if (smp_mdata !== smp_exp) begin
                    n_fail++; $display("FAIL stream_data got=%h exp=%h", smp_mdata, smp_exp);
                end
            end
        end
        n_checks++;
        if (first_pop !== 3) begin n_fail++; $display("FAIL stream_latency got=%0d exp=3", first_pop); end
        n_checks++;
        if (pops !== 20) begin n_fail++; $display("FAIL stream_pops got=%0d exp=20", pops); end
        n_checks++;
        if (last_pop !== 22) begin n_fail++; $display("FAIL stream_gapless last=%0d exp=22", last_pop); end
    endtask

    task automatic test_backpressure();
        int       idx = 0;
        int       pops = 0;
        logic     prev_stall = 1'b0;
        logic [7:0] prev_data = 8'h00;
        for (int k = 0; k < 60; k++) begin
            tick(idx < 16, 8'(idx), k[0]);
            if (smp_push) idx++;
            if (prev_stall) begin
                n_checks++;
                if (smp_mvalid !== 1'b1 || smp_mdata !== prev_data) begin
                    n_fail++;
                    $display("FAIL bp_stable got=%b/%h exp=1/%h", smp_mvalid, smp_mdata, prev_data);
                end
            end
            n_checks++;
            if (smp_count !== exp_count || smp_count > 6) begin
                n_fail++; $display("FAIL bp_count t=%0d got=%0d exp=%0d", k, smp_count, exp_count);
            end
            if (smp_pop) begin
                pops++;
                n_checks++;
                if (smp_mdata !== smp_exp) begin
                    n_fail++; $display("FAIL bp_data got=%h exp=%h", smp_mdata, smp_exp);
                end
            end
            prev_stall = smp_mvalid && !k[0];
            prev_data  = smp_mdata;
        end
        n_checks++;
        if (pops !== 16) begin n_fail++; $display("FAIL bp_pops got=%0d exp=16", pops); end
    endtask

    task automatic test_wrap();
        int pops = 0;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 3; i++) begin
                tick(1'b1, 8'(8'h40 + r * 3 + i), 1'b0);
            end
            for (int k = 0; k < 10 && model_q.size() != 0; k++) begin
                tick(1'b0, 8'h00, 1'b1);
                if (smp_pop) begin
                    pops++;
                    n_checks++;
                    if (smp_mdata !== smp_exp) begin
                        n_fail++; $display("FAIL wrap_data r=%0d got=%h exp=%h", r, smp_mdata, smp_exp);
                    end
                end
            end
        end
        n_checks++;
        if (pops !== 30) begin n_fail++; $display("FAIL wrap_pops got=%0d exp=30", pops); end
    endtask

    task automatic test_reset_mid();
        int pops = 0;
        for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h90 + i), 1'b0);
        n_checks++;
        if (count !== 4'd4) begin n_fail++; $display("FAIL mid_count_before got=%0d exp=4", count); end
        s_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (m_valid !== 1'b0 || count !== 4'd0) begin
            n_fail++; $display("FAIL mid_reset got=%b/%0d exp=0/0", m_valid, count);
        end
        model_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 10; k++) begin
            tick((k == 0), 8'h3C, 1'b1);
            if (smp_pop) begin
                pops++;
                n_checks++;
                if (smp_mdata !== smp_exp) begin
                    n_fail++; $display("FAIL mid_data got=%h exp=%h", smp_mdata, smp_exp);
                end
            end
        end
        n_checks++;
        if (pops !== 1) begin n_fail++; $display("FAIL mid_pops got=%0d exp=1", pops); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 420; k++) begin
            if (k < 400) tick(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            else tick(1'b0, 8'h00, 1'b1);
            n_checks++;
            if (smp_count !== exp_count) begin
                n_fail++; $display("FAIL rand_count t=%0d got=%0d exp=%0d", k, smp_count, exp_count);
            end
            if (smp_pop) begin
                n_checks++;
                if (smp_mdata !== smp_exp) begin
                    n_fail++; $display("FAIL rand_data t=%0d got=%h exp=%h", k, smp_mdata, smp_exp);
                end
            end
        end
        n_checks++;
        if (model_q.size() != 0) begin
            n_fail++; $display("FAIL rand_drain left=%0d exp=0", model_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
